// File: rtl/serv_bufreg_pkg.sv
// Shared types and helpers for the parametrised SERV buffer register.
package serv_bufreg_pkg;

    localparam int unsigned BR_XLEN  = 32;
    localparam int unsigned BR_CNT_W = 5;

    typedef enum logic [1:0] {
        BR_ADD   = 2'd0,
        BR_SHIFT = 2'd1,
        BR_LOAD  = 2'd2,
        BR_RSVD  = 2'd3
    } br_mode_e;

    typedef enum logic [1:0] {
        BR_IDLE = 2'd0,
        BR_RUN  = 2'd1,
        BR_DONE = 2'd2
    } br_state_e;

    // Number of beats needed to cover one 32-bit word at w bits per beat.
    function automatic int unsigned br_beats(input int unsigned w);
        return (w == 0) ? 0 : BR_XLEN / w;
    endfunction

    // Only power-of-two widths up to a byte keep the beat slicing trivial.
    function automatic bit br_w_legal(input int unsigned w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8);
    endfunction

endpackage

// File: rtl/serv_bufreg_adder.sv
// W-bit beat adder; carry-in is ignored on the first beat of a pass.
module serv_bufreg_adder #(
    parameter int unsigned W = 1
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    input  logic         i_beat0,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W:0] full;

    // One beat of the serial add with the carry chain broken at beat 0.
    always_comb begin
        full   = {1'b0, i_a} + {1'b0, i_b} + (W+1)'(i_cin & ~i_beat0);
        o_sum  = full[W-1:0];
        o_cout = full[W];
    end

endmodule

// File: rtl/serv_bufreg_pw.sv
// Buffer register: serial rs1+imm accumulate (W bits/beat) or 1-bit/cycle shift.
module serv_bufreg_pw
    import serv_bufreg_pkg::*;
#(
    parameter int unsigned W   = 1,
    parameter int unsigned MDU = 0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [1:0]   i_mode,
    input  logic         i_stall,
    input  logic         i_mdu_op,
    input  logic         i_rs1_en,
    input  logic         i_imm_en,
    input  logic         i_clr_lsb,
    input  logic         i_sh_signed,
    input  logic [4:0]   i_shamt,
    input  logic [W-1:0] i_rs1,
    input  logic [W-1:0] i_imm,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_q,
    output logic [1:0]   o_lsb,
    output logic [31:0]  o_dbus_adr,
    output logic [31:0]  o_ext_rs1,
    output logic [31:0]  o_data
);

    localparam int unsigned   BEATS     = br_beats(W);
    localparam int unsigned   CW        = BR_CNT_W;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    if (!br_w_legal(W)) begin : g_bad_w
        $error("serv_bufreg_pw: W must be 1, 2, 4 or 8");
    end

    br_state_e     state_q, state_d;
    br_mode_e      mode_q;
    logic [31:0]   data_q;
    logic          carry_q;
    logic [1:0]    lsb_q, lsb_d;
    logic [CW-1:0] cnt_q;
    logic [4:0]    shamt_q;
    logic          busy_q, done_q;

    logic          start_c, step_c, shift_c, beat0_c, last_c, fill_c, imm_kill_c;
    logic [W-1:0]  op_a, op_b, sum, sum_m;
    logic          cout;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= BR_IDLE;
        else          state_q <= state_d;
    end

    // Next state; a zero-length shift skips RUN entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BR_IDLE: if (i_start)
                         state_d = (br_mode_e'(i_mode) == BR_SHIFT && i_shamt == 5'd0)
                                   ? BR_DONE : BR_RUN;
            BR_RUN:  if (!i_stall && last_c) state_d = BR_DONE;
            BR_DONE: state_d = BR_IDLE;
            default: state_d = BR_IDLE;
        endcase
    end

    // Step control decoded from the state and the latched pass parameters.
    always_comb begin
        start_c    = (state_q == BR_IDLE) && i_start;
        step_c     = (state_q == BR_RUN) && !i_stall;
        shift_c    = (mode_q == BR_SHIFT);
        beat0_c    = (cnt_q == '0);
        last_c     = shift_c ? (cnt_q == shamt_q - CW'(1)) : (cnt_q == LAST_BEAT);
        fill_c     = i_sh_signed & data_q[31];
        imm_kill_c = (mode_q == BR_LOAD) || (mode_q == BR_RSVD) || ((MDU != 0) && i_mdu_op);
    end

    // Gated adder operands.
    always_comb begin
        op_a = i_rs1_en ? i_rs1 : '0;
        op_b = (i_imm_en && !imm_kill_c) ? i_imm : '0;
    end

    serv_bufreg_adder #(.W(W)) u_adder (
        .i_a     (op_a),
        .i_b     (op_b),
        .i_cin   (carry_q),
        .i_beat0 (beat0_c),
        .o_sum   (sum),
        .o_cout  (cout)
    );

    // JALR clears bit 0 of the target on the first beat.
    always_comb begin
        sum_m = sum;
        if (beat0_c && i_clr_lsb) sum_m[0] = 1'b0;
    end

    if (W == 1) begin : g_lsb_w1
        // Serial capture: address bit 0 on beat 0, bit 1 on beat 1.
        always_comb begin
            lsb_d = lsb_q;
            if (cnt_q == CW'(0))      lsb_d[0] = sum_m[0];
            else if (cnt_q == CW'(1)) lsb_d[1] = sum_m[0];
        end
    end else begin : g_lsb_wn
        // Both address bits arrive together on beat 0.
        always_comb begin
            lsb_d = lsb_q;
            if (beat0_c) lsb_d = sum_m[1:0];
        end
    end

    // Datapath, beat counter and handshake flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q  <= '0;
            carry_q <= 1'b0;
            lsb_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= BR_ADD;
            shamt_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q <= (state_d != BR_IDLE);
            done_q <= (state_d == BR_DONE);
            if (start_c) begin
                mode_q  <= br_mode_e'(i_mode);
                shamt_q <= i_shamt;
                cnt_q   <= '0;
            end
            if (step_c) begin
                cnt_q <= last_c ? '0 : cnt_q + CW'(1);
                if (shift_c) begin
                    data_q <= {fill_c, data_q[31:1]};
                end else begin
                    data_q  <= {sum_m, data_q[31:W]};
                    carry_q <= cout;
                    lsb_q   <= lsb_d;
                end
            end
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_q        = data_q[W-1:0];
    assign o_lsb      = lsb_q;
    assign o_dbus_adr = {data_q[31:2], 2'b00};
    assign o_ext_rs1  = {data_q[31:2], lsb_q};
    assign o_data     = data_q;

endmodule

// File: tb/tb_serv_bufreg_pw.sv
// Bench for serv_bufreg_pw: W=1 and W=4 instances checked against a word-level model.
module tb_serv_bufreg_pw;

    localparam logic [1:0] M_ADD   = 2'd0;
    localparam logic [1:0] M_SHIFT = 2'd1;
    localparam logic [1:0] M_LOAD  = 2'd2;
    localparam logic [1:0] M_RSVD  = 2'd3;

    typedef struct {
        int          cyc;
        logic        busy1;
        logic [31:0] data;
        logic [1:0]  lsb;
        logic [31:0] dbus;
        logic [31:0] ext;
        logic [3:0]  q;
        logic        post_busy;
        logic        post_done;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start1, start4, stall, rs1_en, imm_en, clr, sgn;
    logic [1:0] mode;
    logic [4:0] shamt;
    logic [0:0] rs1_1, imm_1, q1;
    logic [3:0] rs1_4, imm_4, q4;
    logic busy1, done1, busy4, done4;
    logic [1:0] lsb1, lsb4;
    logic [31:0] dbus1, ext1, data1, dbus4, ext4, data4;

    int sel = 0;
    int total = 0;
    int bad = 0;

    logic        busy_s, done_s;
    logic [1:0]  lsb_s;
    logic [31:0] data_s, dbus_s, ext_s;
    logic [3:0]  q_s;

    assign busy_s = (sel != 0) ? busy4 : busy1;
    assign done_s = (sel != 0) ? done4 : done1;
    assign lsb_s  = (sel != 0) ? lsb4  : lsb1;
    assign data_s = (sel != 0) ? data4 : data1;
    assign dbus_s = (sel != 0) ? dbus4 : dbus1;
    assign ext_s  = (sel != 0) ? ext4  : ext1;
    assign q_s    = (sel != 0) ? q4    : {3'b000, q1};

    always #5 clk = ~clk;

    serv_bufreg_pw #(.W(1), .MDU(0)) u_w1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_mode(mode), .i_stall(stall),
        .i_mdu_op(1'b0), .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr),
        .i_sh_signed(sgn), .i_shamt(shamt), .i_rs1(rs1_1), .i_imm(imm_1),
        .o_busy(busy1), .o_done(done1), .o_q(q1), .o_lsb(lsb1),
        .o_dbus_adr(dbus1), .o_ext_rs1(ext1), .o_data(data1)
    );

    serv_bufreg_pw #(.W(4), .MDU(0)) u_w4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_mode(mode), .i_stall(stall),
        .i_mdu_op(1'b0), .i_rs1_en(rs1_en), .i_imm_en(imm_en), .i_clr_lsb(clr),
        .i_sh_signed(sgn), .i_shamt(shamt), .i_rs1(rs1_4), .i_imm(imm_4),
        .o_busy(busy4), .o_done(done4), .o_q(q4), .o_lsb(lsb4),
        .o_dbus_adr(dbus4), .o_ext_rs1(ext4), .o_data(data4)
    );

    // Word-level reference: what the register holds after an ADD/LOAD pass.
    function automatic logic [31:0] ref_add(input logic [1:0] m, input logic [31:0] a,
                                            input logic [31:0] b, input logic a_en,
                                            input logic b_en, input logic c);
        logic [31:0] r;
        r = (a_en ? a : 32'h0) + ((b_en && m == M_ADD) ? b : 32'h0);
        if (c) r[0] = 1'b0;
        return r;
    endfunction

    // Word-level reference: right shift by n, arithmetic or logical.
    function automatic logic [31:0] ref_shift(input logic [31:0] v, input int n, input logic s);
        logic [31:0] r;
        if (s) r = $signed(v) >>> n;
        else   r = v >> n;
        return r;
    endfunction

    function automatic int beats_of(input int s);
        return (s != 0) ? 8 : 32;
    endfunction

    // Drive one complete pass on the selected instance and capture what it shows at DONE.
    task automatic run_pass(input int s, input logic [1:0] m, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] n, input logic c,
                            input logic sg, input logic a_en, input logic b_en,
                            input int stall_at, input int stall_len, input bit hold,
                            output res_t r);
        int w, bidx;
        bit stl;
        logic [31:0] sa, sb;
        w = (s != 0) ? 4 : 1;
        sel = s; mode = m; shamt = n; clr = c; sgn = sg; rs1_en = a_en; imm_en = b_en;
        if (s != 0) start4 = 1'b1; else start1 = 1'b1;
        bidx = 0;
        r.cyc = 0;
        @(posedge clk); #1;
        r.cyc = 1;
        if (!hold) begin start1 = 1'b0; start4 = 1'b0; end
        r.busy1 = busy_s;
        while (!done_s && r.cyc < 300) begin
            stl = (r.cyc >= stall_at) && (r.cyc < stall_at + stall_len);
            stall = stl;
            sa = a >> (bidx * w);
            sb = b >> (bidx * w);
            rs1_1 = sa[0]; imm_1 = sb[0];
            rs1_4 = sa[3:0]; imm_4 = sb[3:0];
            @(posedge clk); #1;
            if (!stl) bidx++;
            r.cyc++;
        end
        stall = 1'b0;
        r.data = data_s; r.lsb = lsb_s; r.dbus = dbus_s; r.ext = ext_s; r.q = q_s;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        r.post_busy = busy_s;
        r.post_done = done_s;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            sel = s; #1;
            total++;
            if ({data_s, busy_s, done_s, lsb_s, dbus_s, ext_s, q_s} !== '0) begin
                bad++;
                $display("FAIL reset_state s=%0d got data=%h busy=%b done=%b lsb=%b exp all zero",
                         s, data_s, busy_s, done_s, lsb_s);
            end
        end
    endtask

    task automatic test_add(input int s);
        res_t r;
        int nb;
        nb = beats_of(s);
        run_pass(s, M_ADD, 32'h1000_0003, 32'h0000_0005, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, r);
        total++;
        if ({r.data, r.lsb} !== {32'h1000_0008, 2'b00}) begin
            bad++; $display("FAIL add1_result s=%0d got=%h/%b exp=10000008/00", s, r.data, r.lsb);
        end
        total++;
        if (r.cyc !== nb + 1) begin
            bad++; $display("FAIL add1_latency s=%0d got=%0d exp=%0d", s, r.cyc, nb + 1);
        end
        total++;
        if ({r.busy1, r.post_busy, r.post_done} !== 3'b100) begin
            bad++; $display("FAIL add1_handshake s=%0d got=%b exp=100", s, {r.busy1, r.post_busy, r.post_done});
        end
        run_pass(s, M_ADD, 32'h0000_0101, 32'hFFFF_FFFF, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, r);
        total++;
        if ({r.data, r.ext, r.dbus, r.lsb} !== {32'h0000_0100, 32'h0000_0100, 32'h0000_0100, 2'b00}) begin
            bad++; $display("FAIL add2_result s=%0d got data=%h ext=%h dbus=%h lsb=%b exp 100/100/100/00",
                            s, r.data, r.ext, r.dbus, r.lsb);
        end
    endtask

    task automatic test_shift(input int s);
        res_t r;
        run_pass(s, M_LOAD, 32'h8000_0000, 32'h0000_1234, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, r);
        total++;
        if (r.data !== 32'h8000_0000) begin
            bad++; $display("FAIL load_ignores_imm s=%0d got=%h exp=80000000", s, r.data);
        end
        run_pass(s, M_SHIFT, 32'h0, 32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, r);
        total++;
        if ({r.data, r.cyc} !== {32'hF800_0000, 32'd5}) begin
            bad++; $display("FAIL shift_signed s=%0d got=%h cyc=%0d exp=f8000000 cyc=5", s, r.data, r.cyc);
        end
        run_pass(s, M_LOAD, 32'h8000_0000, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, r);
        run_pass(s, M_SHIFT, 32'h0, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, r);
        total++;
        if (r.data !== 32'h0800_0000) begin
            bad++; $display("FAIL shift_logical s=%0d got=%h exp=08000000", s, r.data);
        end
        run_pass(s, M_SHIFT, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, r);
        total++;
        if ({r.data, r.cyc, r.busy1, r.post_busy} !== {32'h0800_0000, 32'd1, 2'b10}) begin
            bad++; $display("FAIL shift_zero s=%0d got=%h cyc=%0d busy=%b/%b exp=08000000 cyc=1 busy=1/0",
                            s, r.data, r.cyc, r.busy1, r.post_busy);
        end
    endtask

    task automatic test_stall(input int s);
        res_t r;
        int nb;
        nb = beats_of(s);
        run_pass(s, M_ADD, 32'h1000_0003, 32'h0000_0005, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 3, 1'b0, r);
        total++;
        if ({r.data, r.cyc} !== {32'h1000_0008, 32'(nb + 4)}) begin
            bad++; $display("FAIL stall_mid s=%0d got=%h cyc=%0d exp=10000008 cyc=%0d", s, r.data, r.cyc, nb + 4);
        end
        run_pass(s, M_ADD, 32'h1000_0003, 32'h0000_0005, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, nb, 2, 1'b0, r);
        total++;
        if ({r.data, r.cyc} !== {32'h1000_0008, 32'(nb + 3)}) begin
            bad++; $display("FAIL stall_last s=%0d got=%h cyc=%0d exp=10000008 cyc=%0d", s, r.data, r.cyc, nb + 3);
        end
    endtask

    task automatic test_rst_mid(input int s);
        res_t r;
        int nb;
        nb = beats_of(s);
        run_pass(s, M_LOAD, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, r);
        sel = s; mode = M_ADD; rs1_en = 1'b1; imm_en = 1'b1; rs1_1 = 1'b1; rs1_4 = 4'hF;
        if (s != 0) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy_s !== 1'b1) begin
            bad++; $display("FAIL rst_mid_inflight s=%0d busy got=%b exp=1", s, busy_s);
        end
        rst_n = 1'b0; #1;
        total++;
        if ({data_s, busy_s, done_s, lsb_s, dbus_s, ext_s, q_s} !== '0) begin
            bad++; $display("FAIL rst_mid_clear s=%0d got data=%h busy=%b done=%b lsb=%b exp all zero",
                            s, data_s, busy_s, done_s, lsb_s);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if ({busy_s, done_s} !== 2'b00) begin
                bad++; $display("FAIL rst_mid_nodone s=%0d got=%b exp=00", s, {busy_s, done_s});
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_pass(s, M_ADD, 32'h1000_0003, 32'h0000_0005, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, r);
        total++;
        if ({r.data, r.cyc} !== {32'h1000_0008, 32'(nb + 1)}) begin
            bad++; $display("FAIL rst_mid_recover s=%0d got=%h cyc=%0d exp=10000008 cyc=%0d", s, r.data, r.cyc, nb + 1);
        end
    endtask

    task automatic test_back_to_back(input int s);
        res_t r;
        logic [31:0] a, b, e;
        int nb;
        nb = beats_of(s);
        a = $urandom; b = $urandom;
        e = ref_add(M_ADD, a, b, 1'b1, 1'b1, 1'b0);
        run_pass(s, M_ADD, a, b, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1, r);
        total++;
        if ({r.data, r.cyc, r.post_busy, r.post_done} !== {e, 32'(nb + 1), 2'b00}) begin
            bad++; $display("FAIL b2b_held_start s=%0d got=%h cyc=%0d post=%b%b exp=%h cyc=%0d post=00",
                            s, r.data, r.cyc, r.post_busy, r.post_done, e, nb + 1);
        end
        a = $urandom;
        run_pass(s, M_LOAD, a, b, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, r);
        total++;
        if ({r.data, r.lsb, r.cyc} !== {a, a[1:0], 32'(nb + 1)}) begin
            bad++; $display("FAIL b2b_second s=%0d got=%h/%b cyc=%0d exp=%h/%b cyc=%0d",
                            s, r.data, r.lsb, r.cyc, a, a[1:0], nb + 1);
        end
        run_pass(s, M_SHIFT, 32'h0, 32'h0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, r);
        e = ref_shift(a, 7, 1'b1);
        total++;
        if ({r.data, r.cyc, r.post_busy} !== {e, 32'd8, 1'b0}) begin
            bad++; $display("FAIL b2b_third s=%0d got=%h cyc=%0d post_busy=%b exp=%h cyc=8 post_busy=0",
                            s, r.data, r.cyc, r.post_busy, e);
        end
    endtask

    task automatic test_add_random(input int s);
        res_t r;
        logic [31:0] a, b, e;
        logic [1:0] m;
        logic ae, be, c;
        logic [3:0] qe;
        int nb, sat, slen;
        nb = beats_of(s);
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 3))
                0, 1:    m = M_ADD;
                2:       m = M_LOAD;
                default: m = M_RSVD;
            endcase
            ae = 1'($urandom_range(0, 7) != 0);
            be = 1'($urandom_range(0, 7) != 0);
            c  = 1'($urandom_range(0, 1));
            sat  = int'($urandom_range(1, nb));
            slen = int'($urandom_range(0, 3));
            e  = ref_add(m, a, b, ae, be, c);
            qe = (s != 0) ? e[3:0] : {3'b000, e[0]};
            run_pass(s, m, a, b, 5'd0, c, 1'b0, ae, be, sat, slen, 1'b0, r);
            total++;
            if ({r.data, r.lsb, r.dbus, r.ext, r.q} !== {e, e[1:0], {e[31:2], 2'b00}, e, qe}) begin
                bad++; $display("FAIL add_rand s=%0d i=%0d mode=%0d got=%h/%b/%h/%h/%h exp=%h/%b/%h/%h/%h",
                                s, i, m, r.data, r.lsb, r.dbus, r.ext, r.q,
                                e, e[1:0], {e[31:2], 2'b00}, e, qe);
            end
            total++;
            if (r.cyc !== nb + 1 + slen) begin
                bad++; $display("FAIL add_rand_latency s=%0d i=%0d got=%0d exp=%0d", s, i, r.cyc, nb + 1 + slen);
            end
        end
    endtask

    task automatic test_shift_random(input int s);
        res_t r;
        logic [31:0] v, e;
        logic [4:0] n;
        logic sg;
        for (int i = 0; i < 6; i++) begin
            v  = $urandom;
            n  = 5'($urandom_range(0, 31));
            sg = 1'($urandom_range(0, 1));
            run_pass(s, M_LOAD, v, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, r);
            run_pass(s, M_SHIFT, 32'h0, 32'h0, n, 1'b0, sg, 1'b0, 1'b0, 0, 0, 1'b0, r);
            e = ref_shift(v, int'(n), sg);
            total++;
            if ({r.data, r.ext, r.cyc} !== {e, {e[31:2], v[1:0]}, 32'(int'(n) + 1)}) begin
                bad++; $display("FAIL shift_rand s=%0d i=%0d v=%h n=%0d sg=%b got=%h ext=%h cyc=%0d exp=%h ext=%h cyc=%0d",
                                s, i, v, n, sg, r.data, r.ext, r.cyc, e, {e[31:2], v[1:0]}, int'(n) + 1);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start1 = 1'b0; start4 = 1'b0; stall = 1'b0; rs1_en = 1'b0; imm_en = 1'b0;
        clr = 1'b0; sgn = 1'b0; mode = M_ADD; shamt = 5'd0;
        rs1_1 = 1'b0; imm_1 = 1'b0; rs1_4 = 4'h0; imm_4 = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) begin
            test_add(s);
            test_shift(s);
            test_stall(s);
            test_rst_mid(s);
            test_back_to_back(s);
            test_add_random(s);
            test_shift_random(s);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
